// File: rtl/mod_updown_counter.sv
// Parametrised modulo up/down counter with load, enable, and wrap or saturate limits.
// Provides a terminal-count output and an overflow pulse for cascading stages.
module mod_updown_counter #(
  parameter int unsigned            WIDTH     = 4,
  parameter logic [WIDTH-1:0]       MAX_COUNT = {WIDTH{1'b1}},
  parameter bit                     SATURATE  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             ovf
);

  logic [WIDTH-1:0] q_nxt;
  logic             ovf_nxt;
  logic             at_max;
  logic             at_zero;

  assign at_max  = (Q == MAX_COUNT);
  assign at_zero = (Q == '0);

  // Next count: load beats enable; at a limit either wrap or hold, and flag it.
  always_comb begin
    q_nxt   = Q;
    ovf_nxt = 1'b0;
    if (load) begin
      q_nxt = (load_val > MAX_COUNT) ? MAX_COUNT : load_val;
    end else if (en) begin
      if (up_dn) begin
        if (at_max) begin
          ovf_nxt = 1'b1;
          q_nxt   = SATURATE ? Q : '0;
        end else begin
          q_nxt = Q + WIDTH'(1);
        end
      end else begin
        if (at_zero) begin
          ovf_nxt = 1'b1;
          q_nxt   = SATURATE ? Q : MAX_COUNT;
        end else begin
          q_nxt = Q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Q   <= '0;
      ovf <= 1'b0;
    end else begin
      Q   <= q_nxt;
      ovf <= ovf_nxt;
    end
  end

  // High in the cycle before a wrapping/clipping edge so a next stage can use it as enable.
  assign tc = en & ~rst & ((up_dn & at_max) | (~up_dn & at_zero));

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: three configurations (4-bit mod 10 wrap, 4-bit mod 10
// saturate, 8-bit full range) checked every cycle against an arithmetic model plus literals.
module tb_mod_updown_counter;

  logic       clk;
  logic       rst;
  logic       en  [3];
  logic       up  [3];
  logic       ld  [3];
  logic [3:0] lv0, lv1;
  logic [7:0] lv2;
  logic [3:0] q0, q1;
  logic [7:0] q2;
  logic       tcs [3];
  logic       ovs [3];

  int  qv  [3];
  int  lvv [3];
  int  mq  [3] = '{0, 0, 0};
  bit  mo  [3] = '{0, 0, 0};
  int  mx  [3] = '{9, 9, 255};
  bit  sat [3] = '{1'b0, 1'b1, 1'b0};
  bit  ck_on = 1'b0;
  int  checks = 0;
  int  errors = 0;

  mod_updown_counter #(.WIDTH(4), .MAX_COUNT(4'd9), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .en(en[0]), .up_dn(up[0]), .load(ld[0]), .load_val(lv0),
    .Q(q0), .tc(tcs[0]), .ovf(ovs[0]));

  mod_updown_counter #(.WIDTH(4), .MAX_COUNT(4'd9), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .en(en[1]), .up_dn(up[1]), .load(ld[1]), .load_val(lv1),
    .Q(q1), .tc(tcs[1]), .ovf(ovs[1]));

  mod_updown_counter #(.WIDTH(8), .MAX_COUNT(8'd255), .SATURATE(1'b0)) u_full (
    .clk(clk), .rst(rst), .en(en[2]), .up_dn(up[2]), .load(ld[2]), .load_val(lv2),
    .Q(q2), .tc(tcs[2]), .ovf(ovs[2]));

  always_comb begin
    qv[0]  = int'(q0);
    qv[1]  = int'(q1);
    qv[2]  = int'(q2);
    lvv[0] = int'(lv0);
    lvv[1] = int'(lv1);
    lvv[2] = int'(lv2);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Count range is 0..mx; modular arithmetic gives the wrap, saturate suppresses the step.
  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        mq[i] = 0;
        mo[i] = 1'b0;
      end else if (ld[i]) begin
        mq[i] = (lvv[i] > mx[i]) ? mx[i] : lvv[i];
        mo[i] = 1'b0;
      end else if (en[i]) begin
        if (up[i]) begin
          mo[i] = (mq[i] == mx[i]);
          if (!(sat[i] && mo[i])) mq[i] = (mq[i] + 1) % (mx[i] + 1);
        end else begin
          mo[i] = (mq[i] == 0);
          if (!(sat[i] && mo[i])) mq[i] = (mq[i] + mx[i]) % (mx[i] + 1);
        end
      end else begin
        mo[i] = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (ck_on) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("model_q%0d", i), qv[i], mq[i]);
        chk($sformatf("model_ovf%0d", i), int'(ovs[i]), int'(mo[i]));
        chk($sformatf("model_tc%0d", i), int'(tcs[i]),
            int'(en[i] && !rst && ((up[i] && mq[i] == mx[i]) || (!up[i] && mq[i] == 0))));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic idle_all();
    for (int i = 0; i < 3; i++) begin
      en[i] = 1'b0;
      up[i] = 1'b1;
      ld[i] = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_all();
    lv0 = '0;
    lv1 = '0;
    lv2 = '0;
    en[0] = 1'b1;
    up[0] = 1'b0;
    #3;
    chk("rst_q", qv[0], 0);
    chk("rst_ovf", int'(ovs[0]), 0);
    chk("rst_tc", int'(tcs[0]), 0);
    #7;
    rst   = 1'b0;
    up[0] = 1'b1;
    ck_on = 1'b1;

    // 1: up count through the 9->0 wrap
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("up_q_%0d", k), qv[0], k % 10);
      chk($sformatf("up_ovf_%0d", k), int'(ovs[0]), (k == 10) ? 1 : 0);
      if (k == 9) chk("up_tc_at9", int'(tcs[0]), 1);
      if (k == 8) chk("up_tc_at8", int'(tcs[0]), 0);
    end

    // 2: down wrap then direction change
    en[0] = 1'b0; ld[0] = 1'b1; lv0 = 4'd2;
    tick();
    chk("dn_load2", qv[0], 2);
    ld[0] = 1'b0; en[0] = 1'b1; up[0] = 1'b0;
    tick(); chk("dn_q1", qv[0], 1); chk("dn_ovf1", int'(ovs[0]), 0);
    tick(); chk("dn_q0", qv[0], 0); chk("dn_tc0", int'(tcs[0]), 1);
    tick(); chk("dn_q9", qv[0], 9); chk("dn_ovf9", int'(ovs[0]), 1);
    up[0] = 1'b1;
    tick(); chk("dir_q0", qv[0], 0); chk("dir_ovf0", int'(ovs[0]), 1);
    tick(); chk("dir_q1", qv[0], 1); chk("dir_ovf1", int'(ovs[0]), 0);
    idle_all();

    // 3: saturate mode
    ld[1] = 1'b1; lv1 = 4'd7;
    tick(); chk("sat_load7", qv[1], 7);
    ld[1] = 1'b0; en[1] = 1'b1; up[1] = 1'b1;
    tick(); chk("sat_q8", qv[1], 8); chk("sat_ovf8", int'(ovs[1]), 0);
    tick(); chk("sat_q9", qv[1], 9); chk("sat_ovf9", int'(ovs[1]), 0);
    tick(); chk("sat_q9b", qv[1], 9); chk("sat_ovf9b", int'(ovs[1]), 1);
    tick(); chk("sat_q9c", qv[1], 9); chk("sat_ovf9c", int'(ovs[1]), 1);
    en[1] = 1'b0; ld[1] = 1'b1; lv1 = 4'd1;
    tick(); chk("sat_load1", qv[1], 1); chk("sat_ovf_ld", int'(ovs[1]), 0);
    ld[1] = 1'b0; en[1] = 1'b1; up[1] = 1'b0;
    tick(); chk("sat_dn_q0", qv[1], 0); chk("sat_dn_ovf0", int'(ovs[1]), 0);
    tick(); chk("sat_dn_q0b", qv[1], 0); chk("sat_dn_ovf1", int'(ovs[1]), 1);
    idle_all();

    // 4: load beats enable, out-of-range load clamps
    ld[0] = 1'b1; en[0] = 1'b1; lv0 = 4'd12;
    tick(); chk("clamp_q", qv[0], 9); chk("clamp_ovf", int'(ovs[0]), 0);
    lv0 = 4'd3;
    tick(); chk("ldpri_q", qv[0], 3);
    idle_all();

    // 5: async reset mid-count, hold, first count after release
    ld[0] = 1'b1; lv0 = 4'd4;
    tick();
    ld[0] = 1'b0; en[0] = 1'b1; up[0] = 1'b1;
    tick(); chk("pre_rst_q5", qv[0], 5);
    rst = 1'b1;
    #1;
    chk("async_rst_q", qv[0], 0);
    chk("async_rst_ovf", int'(ovs[0]), 0);
    chk("async_rst_tc", int'(tcs[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    en[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("hold_q_%0d", k), qv[0], 0);
      chk($sformatf("hold_tc_%0d", k), int'(tcs[0]), 0);
    end
    en[0] = 1'b1;
    tick(); chk("post_rst_q1", qv[0], 1);
    idle_all();

    // 6: full-range 8-bit natural wrap
    ld[2] = 1'b1; lv2 = 8'd254;
    tick(); chk("full_load", qv[2], 254);
    ld[2] = 1'b0; en[2] = 1'b1; up[2] = 1'b1;
    tick(); chk("full_q255", qv[2], 255); chk("full_tc", int'(tcs[2]), 1);
    chk("full_ovf255", int'(ovs[2]), 0);
    tick(); chk("full_q0", qv[2], 0); chk("full_ovf0", int'(ovs[2]), 1);
    idle_all();
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_updown_counter.md
# mod_updown_counter

Parametrised synchronous modulo up/down counter. It is the general-purpose successor to the fixed 4-bit ripple counter and is used wherever the design needs a programmable-width, programmable-modulus event or cycle counter. Features:
- direction control
- synchronous parallel load
- count enable
- wrap or saturate mode at the count limits
- terminal-count output and overflow pulse for cascading

## Interface
Parameters:
- WIDTH, default 4: counter width in bits; legal range 1–32.
- MAX_COUNT, default 2**WIDTH-1: highest count value; legal range 1 to 2**WIDTH-1. The count range is 0..MAX_COUNT.
- SATURATE, default 0: selects the limit behaviour.
  - 0: wrap at the limits (MAX_COUNT→0 counting up, 0→MAX_COUNT counting down).
  - 1: hold at the limit.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  count enable.
- up_dn  input  1  direction: 1 = up, 0 = down; sampled at each edge.
- load  input  1  synchronous parallel load strobe.
- load_val  input  WIDTH  value loaded when load=1.
- Q  output  WIDTH  current count, registered.
- tc  output  1  terminal count, combinational from Q, en, up_dn and rst.
- ovf  output  1  overflow/underflow event, registered, one bit per edge.

## Operation
Edge priority (highest first): rst, load, en. With none of them active, Q holds.

Reset:
- Asserting rst forces Q=0 and ovf=0 immediately, with no clock edge required.
- tc is forced to 0 while rst=1.

Load (load=1):
- Q <= min(load_val, MAX_COUNT). Out-of-range values clamp to MAX_COUNT.
- Load overrides en and up_dn.
- ovf <= 0.

Count (en=1, load=0):
- Up, Q < MAX_COUNT: Q <= Q+1, ovf <= 0.
- Up, Q == MAX_COUNT:
  - SATURATE=0: Q <= 0.
  - SATURATE=1: Q holds.
  - Either mode: ovf <= 1.
- Down, Q > 0: Q <= Q-1, ovf <= 0.
- Down, Q == 0:
  - SATURATE=0: Q <= MAX_COUNT.
  - SATURATE=1: Q holds.
  - Either mode: ovf <= 1.

Idle (en=0, load=0): Q holds, ovf <= 0.

Terminal count: tc = en & ~rst & ((up_dn & Q==MAX_COUNT) | (~up_dn & Q==0)). tc is high in the cycle before the edge that wraps or clips, so the next counter stage can use it as its enable.

Arithmetic:
- Internal compare and increment are done at WIDTH bits.
- Q never takes a value above MAX_COUNT, including immediately after a load.
- When MAX_COUNT = 2**WIDTH-1, natural binary wrap is the required behaviour.

## Timing
- Latency: one clock edge from en/load/up_dn to the new Q; ovf updates on the same edge as the wrapping or clipping Q update.
- ovf is a one-cycle pulse per event. In saturate mode it stays high on every consecutive clipped edge.
- Direction changes take effect at the first edge at which the new up_dn value is sampled. There is no dead cycle.
- Simultaneous load and en: load wins and no count step occurs.
- Reset mid-count:
  - Q and ovf clear asynchronously during the cycle.
  - Release rst away from the clk edge. The first count happens on the first rising edge after release, giving Q=1 (counting up).
- Unused high bits: none. Q is exactly WIDTH bits, and all outputs are driven in every state.

## Test plan
Unless stated otherwise: WIDTH=4, MAX_COUNT=9, SATURATE=0, 10 ns clock.
1. Reset and up count.
   - Stimulus: rst=1 for 10 ns, then en=1, up_dn=1.
   - Response: Q=0 during reset; then Q=1,2,…,9,0 over 10 edges.
   - tc=1 only while Q=9.
   - ovf=1 for exactly the one cycle after the 9→0 edge.
2. Down wrap and direction change.
   - Stimulus: from Q=2 with up_dn=0 and en=1, clock 3 edges; then set up_dn=1 and clock 2 edges.
   - Response: Q=1,0,9 with ovf after the 0→9 edge; then Q=0 (ovf=1), then Q=1.
3. Saturate mode (SATURATE=1).
   - Stimulus: load 7, then count up 4 edges.
   - Response: Q=8,9,9,9, with ovf=0,0,1,1.
   - Stimulus: count down from 1.
   - Response: Q=0,0, with ovf=0,1.
4. Load priority and clamp.
   - Stimulus: load=1 with load_val=12 and en=1.
   - Response: Q=9, ovf=0.
   - Stimulus: load_val=3 with load=1.
   - Response: Q=3, no increment.
5. Asynchronous reset mid-count and hold.
   - Stimulus: assert rst 3 ns after the edge at Q=5.
   - Response: Q=0 within that cycle, before the next edge.
   - Stimulus: after release, set en=0 for 4 edges.
   - Response: Q stays 0 and tc=0.
6. Full-range width (WIDTH=8, MAX_COUNT=255).
   - Stimulus: count up from 254.
   - Response: Q=255 then 0, with ovf=1 after the wrap.
